// File: rtl/instr_mem_loader.sv
// Boot loader: framed byte stream -> little-endian instruction words.
// Holds the CPU in reset until a full frame with a good checksum lands.
module instr_mem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic                  o_mem_wr_en,
  output logic [ADDR_WIDTH-1:0] o_mem_wr_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wr_data,
  output logic                  o_cpu_reset_n,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  localparam logic [16:0] CAP = 17'(2 ** (ADDR_WIDTH - 2));

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] len_q;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [7:0]  xsum;
  logic [23:0] word_buf;
  logic        accept;
  logic [15:0] len_full;
  logic        last_word;

  assign accept    = i_rx_valid & o_rx_ready;
  assign len_full  = {i_rx_data, len_q[7:0]};
  assign last_word = (word_idx == len_q - 16'd1);

  assign o_rx_ready    = (state != S_DONE) && (state != S_ERROR);
  assign o_busy        = (state == S_LEN_HI) || (state == S_DATA) ||
                         (state == S_CHECK);
  assign o_done        = (state == S_DONE);
  assign o_error       = (state == S_ERROR);
  assign o_cpu_reset_n = (state == S_DONE);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= S_LEN_LO;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_LEN_LO: if (accept) state_nxt = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if ({1'b0, len_full} > CAP) state_nxt = S_ERROR;
          else if (len_full == 16'd0) state_nxt = S_CHECK;
          else                        state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && byte_cnt == 2'd3 && last_word)
          state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (accept)
          state_nxt = (i_rx_data == xsum) ? S_DONE : S_ERROR;
      end
      default: state_nxt = state;
    endcase
  end

  // Bytes shift in from the top, so after three bytes word_buf = {b2,b1,b0}.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      len_q         <= '0;
      word_idx      <= '0;
      byte_cnt      <= '0;
      xsum          <= '0;
      word_buf      <= '0;
      o_mem_wr_en   <= 1'b0;
      o_mem_wr_addr <= '0;
      o_mem_wr_data <= '0;
    end else begin
      o_mem_wr_en <= 1'b0;
      if (accept) begin
        unique case (state)
          S_LEN_LO: len_q[7:0]  <= i_rx_data;
          S_LEN_HI: len_q[15:8] <= i_rx_data;
          S_DATA: begin
            xsum     <= xsum ^ i_rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              o_mem_wr_en   <= 1'b1;
              o_mem_wr_addr <= {word_idx[ADDR_WIDTH-3:0], 2'b00};
              o_mem_wr_data <= {i_rx_data, word_buf};
              word_idx      <= word_idx + 16'd1;
            end else begin
              word_buf <= {i_rx_data, word_buf[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Boot-time program loader that sits directly upstream of `cpu_top`. It receives a framed byte stream over a valid/ready interface and assembles little-endian 32-bit instruction words. It writes those words into the instruction-fetch memory at byte addresses 0, 4, 8, and so on, and holds the CPU in reset until a complete frame with a correct checksum has been written. It replaces direct testbench pokes of `instr_mem` with a synthesizable load path.

## Interface
- `DATA_WIDTH`, default 32: instruction word width. Fixed at 32; the byte-assembly logic assumes 4 bytes per word.
- `ADDR_WIDTH`, default 10: byte-address width of the instruction memory. Capacity is `2**ADDR_WIDTH/4` words.
- `i_clk`  in  1  system clock.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_rx_data`  in  8  stream byte.
- `i_rx_valid`  in  1  `i_rx_data` is valid.
- `o_rx_ready`  out  1  loader accepts a byte this cycle.
- `o_mem_wr_en`  out  1  one-cycle instruction-memory write strobe.
- `o_mem_wr_addr`  out  `ADDR_WIDTH`  byte address, always word-aligned (bits [1:0] = 0).
- `o_mem_wr_data`  out  `DATA_WIDTH`  assembled instruction word.
- `o_cpu_reset_n`  out  1  active-low reset to `cpu_top`.
- `o_busy`  out  1  a frame is in progress (past `LEN_LO`, not yet `DONE` or `ERROR`).
- `o_done`  out  1  load succeeded; sticky.
- `o_error`  out  1  load failed; sticky.

## Operation
- **Frame format:** `LEN_LO`, `LEN_HI` (16-bit word count N, little-endian), then N×4 payload bytes (each word little-endian: first byte → [7:0]), then 1 checksum byte.
- **Checksum:** the XOR of all payload bytes only. Length bytes are excluded.
- **Handshake:** a byte is accepted on a cycle where `i_rx_valid & o_rx_ready` is high. `o_rx_ready` is combinational from state: 1 in `LEN_LO`, `LEN_HI`, `DATA`, `CHECK`; 0 in `DONE` and `ERROR`. `i_rx_data` is ignored when not accepted.
- **State `LEN_LO`:** accept → latch N[7:0] → `LEN_HI`.
- **State `LEN_HI`:** accept → latch N[15:8], then:
  - if N > capacity → `ERROR`;
  - else if N == 0 → `CHECK`;
  - else → `DATA`.
- **State `DATA`:** 2-bit byte counter, word index counter, running XOR.
  - On the 4th byte of a word, register the word and address (word index × 4) and pulse `o_mem_wr_en` for one cycle.
  - When word N−1 completes → `CHECK`.
- **State `CHECK`:** accept → compare the byte with the running XOR. Match → `DONE`; mismatch → `ERROR`.
- **State `DONE`:** `o_done`=1, `o_cpu_reset_n`=1. Held until `i_reset_n`.
- **State `ERROR`:** `o_error`=1, `o_cpu_reset_n`=0. Held until `i_reset_n`.
- **Partial writes:** words written before an error remain in memory. The CPU is never released after an error.
- **Width rules:**
  - Word index is 16 bits. The address is word index[`ADDR_WIDTH`−3:0] concatenated with 2'b00; the capacity check guarantees no wrap.
  - N == capacity is legal and fills memory exactly, ending at address `2**ADDR_WIDTH`−4.
- **Stalls:** gaps in `i_rx_valid` freeze all counters. There is no timeout.

## Timing
- **Reset values:** state `LEN_LO`, `o_rx_ready`=1, `o_mem_wr_en`=0, `o_mem_wr_addr`=0, `o_mem_wr_data`=0, `o_cpu_reset_n`=0, `o_busy`=0, `o_done`=0, `o_error`=0. All counters and the XOR accumulator are 0.
- **Write latency:** `o_mem_wr_en`, `o_mem_wr_addr` and `o_mem_wr_data` are registered. They assert the cycle after the 4th byte of a word is accepted and last exactly one cycle.
- **Back-to-back:** at full rate (one byte per cycle) there is one write strobe every 4 cycles. No back-pressure is ever applied during `DATA`.
- **Release:** `o_cpu_reset_n` and `o_done` rise the cycle after a matching checksum byte is accepted, together with the state entering `DONE`.
  - For N ≥ 1 the final write strobe coincides with this cycle, so the CPU samples its first fetch no earlier than one cycle after the last write.
- **Reset mid-frame:** asserting `i_reset_n` returns everything to reset values immediately (asynchronously). Any pending write strobe is dropped. The next byte is treated as `LEN_LO`.

## Test plan
- **Two-word load:** send 02 00 B3 82 A1 40 93 00 F0 00 B3 at full rate. Required: writes (addr 0x000, data 0x40A182B3) then (addr 0x004, data 0x00F00093), one cycle each. `o_done`=1 and `o_cpu_reset_n`=1 one cycle after the last byte, with `o_error`=0.
- **Bad checksum:** send the same frame with a final byte of 0xB2. Required: both writes occur, `o_error`=1, `o_cpu_reset_n` stays 0, and `o_rx_ready`=0 thereafter.
- **Empty frame:** send 00 00 00. Required: no write strobe and `o_done`=1. Sending 00 00 01 instead gives `o_error`=1.
- **Over capacity (`ADDR_WIDTH`=10):** send 01 01 (N=257). Required: `o_error`=1 immediately after `LEN_HI` and no writes. With N=256, the last write is at address 0x3FC and the load completes with `o_done`=1.
- **Throttled valid:** send the two-word frame with random 0–3 cycle gaps between bytes. Required: identical writes and completion, with no extra strobes.
- **Reset mid-frame:** assert `i_reset_n`=0 after the 6th byte, then resend the full two-word frame. Required: all outputs return to reset values, then exactly two writes and `o_done`=1.
